// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding select encodings,
// memory-wait state enum and the operand forwarding helper.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERR     = 2'd2
   } mem_state_e;

   // M-stage result is younger than W, so its match wins.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] wr_m,
      input logic       we_m,
      input logic [4:0] wr_w,
      input logic       we_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if ((src != 5'd0) && (src == wr_m) && we_m)
         sel = FWD_M;
      else if ((src != 5'd0) && (src == wr_w) && we_w)
         sel = FWD_W;
      return sel;
   endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory ready handshake: tracks consecutive wait cycles, raises a
// sticky error after MEM_TIMEOUT of them and reports when the pipe must hold.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | no outstanding wait; stalls only if a request misses ready
//   MEMWAIT | access outstanding; cnt_q counts wait cycles from 1
//   ERR     | timed out; pipeline frozen and error held until reset
module mem_wait_fsm
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req_i,
   input  logic mem_ready_i,
   output logic memstall_o,
   output logic mem_err_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

   mem_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mem_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_req_i && !mem_ready_i) begin
                  state_q <= MEMWAIT;
                  cnt_q   <= CNT_W'(1);
               end
            end
            // The M stage is frozen here, so mem_req_i carries no new information.
            MEMWAIT: begin
               if (mem_ready_i) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
               end else if (cnt_q == TIMEOUT_C) begin
                  state_q   <= ERR;
                  mem_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ERR: begin
               mem_err_q <= 1'b1;
            end
            default: begin
               state_q <= RUN;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign memstall_o = (state_q == MEMWAIT) || (state_q == ERR) ||
                       ((state_q == RUN) && mem_req_i && !mem_ready_i);
   assign mem_err_o  = mem_err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch stalls and
// memory-wait freeze for the five-stage datapath registers.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic       BranchD,
   input  logic       PCSrcD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic       RegWriteE,
   input  logic       MemtoRegE,
   input  logic [4:0] WriteRegM,
   input  logic       RegWriteM,
   input  logic       MemtoRegM,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteW,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       RegClrD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       MemErr
);

   logic memstall;
   logic mem_err;
   logic lwstall;
   logic branchstall;
   logic hz;

   mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_mem_wait (
      .clk         (clk),
      .rst_n       (reset),
      .mem_req_i   (MemReqM),
      .mem_ready_i (MemReadyM),
      .memstall_o  (memstall),
      .mem_err_o   (mem_err)
   );

   assign lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
   assign branchstall = BranchD &&
                        ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                         (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
   assign hz          = lwstall || branchstall;

   // Everything is forced low while reset is held, including the selects.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      RegClrD   = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      MemErr    = 1'b0;
      if (reset) begin
         StallF    = hz || memstall;
         StallD    = hz || memstall;
         StallE    = memstall;
         StallM    = memstall;
         FlushW    = memstall;
         // A frozen E register must not also be bubbled.
         FlushE    = hz && !memstall;
         // A taken branch on stale operands must not squash D.
         RegClrD   = PCSrcD && !(hz || memstall);
         ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
         ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
         ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
         ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
         MemErr    = mem_err;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued as each
// step is driven and popped when the outputs are sampled after the negedge.
module tb_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       BranchD, PCSrcD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
   logic       MemReqM, MemReadyM, RegWriteW;
   logic       StallF, StallD, StallE, StallM, RegClrD, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, MemErr;

   logic [13:0] obs;
   int          n_pass;
   int          n_total;

   typedef struct {
      string       tag;
      logic [13:0] v;
   } exp_t;
   exp_t sb_q[$];

   localparam logic [13:0] Z = 14'h0;

   hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_W       (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .RsD       (RsD),
      .RtD       (RtD),
      .BranchD   (BranchD),
      .PCSrcD    (PCSrcD),
      .RsE       (RsE),
      .RtE       (RtE),
      .WriteRegE (WriteRegE),
      .RegWriteE (RegWriteE),
      .MemtoRegE (MemtoRegE),
      .WriteRegM (WriteRegM),
      .RegWriteM (RegWriteM),
      .MemtoRegM (MemtoRegM),
      .MemReqM   (MemReqM),
      .MemReadyM (MemReadyM),
      .WriteRegW (WriteRegW),
      .RegWriteW (RegWriteW),
      .StallF    (StallF),
      .StallD    (StallD),
      .StallE    (StallE),
      .StallM    (StallM),
      .RegClrD   (RegClrD),
      .FlushE    (FlushE),
      .FlushW    (FlushW),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE),
      .ForwardAD (ForwardAD),
      .ForwardBD (ForwardBD),
      .MemErr    (MemErr)
   );

   assign obs = {StallF, StallD, StallE, StallM, RegClrD, FlushE, FlushW,
                 ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemErr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [13:0] ev(input logic sfd, input logic sem,
                                      input logic clr, input logic fe,
                                      input logic [1:0] fae, input logic [1:0] fbe,
                                      input logic fad, input logic fbd,
                                      input logic err);
      return {sfd, sfd, sem, sem, clr, fe, sem, fae, fbe, fad, fbd, err};
   endfunction

   task automatic clr_in();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      BranchD = 0; PCSrcD = 0; RegWriteE = 0; MemtoRegE = 0;
      RegWriteM = 0; MemtoRegM = 0; MemReqM = 0; MemReadyM = 0; RegWriteW = 0;
   endtask

   task automatic expect_out(input string tag, input logic [13:0] e);
      exp_t x;
      sb_q.push_back('{tag, e});
      #1;
      x = sb_q.pop_front();
      n_total++;
      assert (obs === x.v) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      clr_in();
      reset = 1'b1;
      #2 reset = 1'b0;

      // Reset gating with hazard-provoking inputs applied
      @(negedge clk);
      RsE = 5; WriteRegM = 5; RegWriteM = 1; MemReqM = 1;
      MemtoRegE = 1; RtE = 8; RsD = 8; PCSrcD = 1;
      expect_out("reset_gate", Z);

      @(negedge clk); clr_in(); reset = 1'b1;
      expect_out("idle", Z);

      // E-stage forwarding priority
      @(negedge clk); clr_in();
      RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
      expect_out("fwdAE_M", ev(0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0));
      @(negedge clk); RegWriteM = 0;
      expect_out("fwdAE_W", ev(0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
      @(negedge clk); RsE = 0;
      expect_out("fwdAE_r0", Z);
      @(negedge clk); clr_in();
      RsE = 9; RtE = 7; WriteRegM = 9; RegWriteM = 1; WriteRegW = 7; RegWriteW = 1;
      expect_out("fwdBE_W", ev(0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0));

      // D-stage (branch compare) forwarding
      @(negedge clk); clr_in();
      RsD = 9; RtD = 4; WriteRegM = 9; RegWriteM = 1;
      expect_out("fwdAD", ev(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0));
      @(negedge clk); clr_in();
      RsD = 0; RtD = 6; WriteRegM = 6; RegWriteM = 1;
      expect_out("fwdBD", ev(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0));

      // Load-use stalls
      @(negedge clk); clr_in();
      MemtoRegE = 1; RtE = 8; RsD = 8;
      expect_out("lw_rs", ev(1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk); MemtoRegE = 0;
      expect_out("lw_clear", Z);
      @(negedge clk); clr_in();
      MemtoRegE = 1; RtE = 12; RtD = 12; RsD = 3;
      expect_out("lw_rt", ev(1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0));

      // Branch stalls and taken-branch clear
      @(negedge clk); clr_in();
      BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; PCSrcD = 1;
      expect_out("br_E", ev(1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk); clr_in();
      BranchD = 1; RtD = 4; MemtoRegM = 1; WriteRegM = 4; RegWriteM = 1; PCSrcD = 1;
      expect_out("br_Mload", ev(1, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0));
      @(negedge clk); clr_in();
      BranchD = 1; PCSrcD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 5;
      expect_out("br_taken", ev(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0));

      // Zero-wait memory access
      @(negedge clk); clr_in();
      MemReqM = 1; MemReadyM = 1;
      expect_out("mem_zero_wait", Z);

      // Three wait cycles, ready on the fourth, release on the fifth
      @(negedge clk); clr_in(); MemReqM = 1;
      expect_out("wait1", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk); MemtoRegE = 1; RtE = 8; RsD = 8;
      expect_out("wait2_lw", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk); clr_in(); PCSrcD = 1;
      expect_out("wait3_br", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk); clr_in(); MemReqM = 1; MemReadyM = 1;
      expect_out("wait4_ready", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk); clr_in();
      expect_out("wait_release", Z);

      // Timeout: one RUN miss plus four MEMWAIT cycles, then ERR
      @(negedge clk); clr_in(); MemReqM = 1;
      expect_out("to_run", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         expect_out($sformatf("to_wait%0d", i), ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      end
      @(negedge clk); clr_in(); MemReadyM = 1;
      expect_out("err_enter", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1));
      @(negedge clk); clr_in(); MemtoRegE = 1; RtE = 8; RsD = 8;
      expect_out("err_hold", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1));
      @(negedge clk); reset = 1'b0;
      expect_out("err_reset", Z);
      @(negedge clk); clr_in(); reset = 1'b1;
      expect_out("err_cleared", Z);

      // Reset in the middle of a wait
      @(negedge clk); clr_in(); MemReqM = 1;
      expect_out("mid_run", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk);
      expect_out("mid_wait", ev(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
      @(negedge clk); reset = 1'b0;
      expect_out("mid_reset", Z);
      @(negedge clk); clr_in(); reset = 1'b1;
      expect_out("mid_after", Z);
      @(negedge clk); MemReqM = 1; MemReadyM = 1;
      expect_out("mid_zero_wait", Z);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control-side counterpart of the pipeline stage registers: computes every stall, flush and clear they consume (StallF, StallD, RegClrD, FlushE), plus the new StallE, StallM and FlushW enables.
- Computes the forwarding selects for E-stage and D-stage (branch compare) operands.
- Adds sequential data-memory wait handling: a ready handshake FSM with a timeout counter and a sticky error flag.
- Sits beside the datapath and is driven by register numbers and control bits from the D, E, M and W stages.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive memory-wait cycles before the error state.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RsD, RtD  in  5 each  D-stage source registers.
- BranchD  in  1  D-stage instruction is a branch.
- PCSrcD  in  1  branch taken (raw, from D-stage compare).
- RsE, RtE  in  5 each  E-stage source registers.
- WriteRegE  in  5  E-stage destination register.
- RegWriteE, MemtoRegE  in  1 each  E-stage control.
- WriteRegM  in  5  M-stage destination register.
- RegWriteM, MemtoRegM  in  1 each  M-stage control.
- MemReqM  in  1  M-stage performs a data-memory access.
- MemReadyM  in  1  data memory completes the access this cycle.
- WriteRegW  in  5  W-stage destination register.
- RegWriteW  in  1  W-stage control.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- RegClrD  out  1  clear the D register.
- FlushE  out  1  clear the E register (bubble).
- FlushW  out  1  clear the W register (bubble).
- ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = ResultW, 10 = ALUOutM.
- ForwardAD, ForwardBD  out  1 each  1 = ALUOutM into the branch comparator.
- MemErr  out  1  sticky memory-timeout error.

Behaviour:
- Reset (reset = 0, async): state RUN, counter 0, MemErr 0. All outputs 0 while reset is low, including forwarding selects (gated).
- Forwarding (combinational), operand A shown, B identical with Rt:
  - ForwardAE = 10 if RsE != 0 and RsE == WriteRegM and RegWriteM.
  - Otherwise 01 if RsE != 0 and RsE == WriteRegW and RegWriteW.
  - Otherwise 00. The M-stage match has priority over the W-stage match.
  - ForwardAD = (RsD != 0) and RsD == WriteRegM and RegWriteM.
- Load-use stall: lwstall = MemtoRegE and (RtE == RsD or RtE == RtD).
- Branch stall: branchstall = BranchD and ((RegWriteE and WriteRegE in {RsD, RtD}) or (MemtoRegM and WriteRegM in {RsD, RtD})).
- Memory stall: memstall = (state == MEMWAIT) or (state == RUN and MemReqM and not MemReadyM) or (state == ERR).
- Stall and flush outputs:
  - hz = lwstall or branchstall.
  - StallF = StallD = hz or memstall.
  - StallE = StallM = FlushW = memstall.
  - FlushE = hz and not memstall; the E register is frozen, so no bubble is injected.
  - RegClrD = PCSrcD and not (hz or memstall). A taken branch evaluated on stale operands must not clear D.
- FSM states are RUN, MEMWAIT and ERR (registered).
- RUN:
  - If MemReqM and not MemReadyM, go to MEMWAIT and set cnt to 1.
  - Otherwise stay in RUN.
- MEMWAIT:
  - If MemReadyM, go to RUN and clear cnt. Stalls are still asserted in the ready cycle and release the next cycle.
  - Otherwise, if cnt == MEM_TIMEOUT, go to ERR and set MemErr to 1.
  - Otherwise increment cnt.
  - MemReqM is ignored here; the M stage is frozen.
- ERR: terminal. All stalls held at 1, FlushW = 1, MemErr = 1 until reset.
- Zero-wait access (MemReqM and MemReadyM in the same cycle) causes no stall and stays in RUN.
- Latency: hazard outputs are combinational (0 cycles). FSM state and cnt update on clk.
- Reset mid-wait returns immediately to RUN with cnt 0 and MemErr 0.

Decomposition:
- Package hazard_pkg holds the forward-select constants (FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10) and the state enum {RUN, MEMWAIT, ERR}.
- One sub-module, mem_wait_fsm: the FSM, counter and MemErr; its output is memstall.
- Forwarding and stall equations stay in hazard_ctrl.

Test Plan:
- RsE = 5, WriteRegM = 5, RegWriteM = 1, WriteRegW = 5, RegWriteW = 1 -> ForwardAE = 10. Then RegWriteM = 0 -> 01. Then RsE = 0 -> 00.
- MemtoRegE = 1, RtE = 8, RsD = 8 -> StallF = StallD = FlushE = 1, StallE = 0. Next cycle with MemtoRegE = 0 -> all 0.
- BranchD = 1, RsD = 3, RegWriteE = 1, WriteRegE = 3, PCSrcD = 1 -> StallD = 1, FlushE = 1, RegClrD = 0.
- MemReqM = 1 with MemReadyM low for 3 cycles, then high -> StallF..StallM and FlushW = 1 for 4 cycles, FlushE = 0, release on the 5th cycle, MemErr = 0.
- MEM_TIMEOUT = 4, MemReadyM never rises -> ERR entered after the 4th wait cycle, MemErr = 1 and held. Drive reset = 0 -> MemErr = 0, all outputs 0.
- Load-use hazard during a memory wait -> FlushE = 0, StallE = 1. PCSrcD = 1 during the wait -> RegClrD = 0.
